// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
package rv32_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry circular queue of {pc, instr} pairs with synchronous flush.
module fetch_fifo
  import rv32_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // At full, wr_ptr == rd_ptr: a push+pop overwrites the slot being popped,
  // and rd_ptr moves on to the older surviving entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= wr_entry;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/rv32_fetch_unit.sv
// Program counter, ROM address drive and decode-side handshake for the RV32I core.
module rv32_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] idata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            misalign_err
);
  // Handshake: an entry transfers on any rising edge where out_valid and
  // out_ready are both high; the head is held stable while valid & ~ready.
  logic [XLEN-1:0] pc;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign pop      = out_valid & out_ready;
  assign push     = ~redirect_valid & ((count < 2'd2) | pop);
  assign wr_entry = '{pc: pc, instr: idata};

  fetch_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_target[XLEN-1:2], 2'b00};
        if (is_misaligned(redirect_target)) misalign_err <= 1'b1;
      end else if (push) begin
        pc <= pc + PC_STEP;
      end
    end
  end

  assign iaddr     = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
endmodule
